// File: rtl/async_fifo_rd_streamer_if.sv
// rtl/async_fifo_rd_streamer_if.sv - valid/ready output stream of the FIFO read streamer
interface async_fifo_rd_streamer_if #(
    parameter int DSIZE = 16
);
    logic             m_valid;
    logic             m_ready;
    logic [DSIZE-1:0] m_data;
    logic             m_last;

    modport master (output m_valid, output m_data, output m_last, input m_ready);
    modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/async_fifo_rd_streamer.sv
// rtl/async_fifo_rd_streamer.sv - pops the async FIFO into a 2-entry skid buffer and streams PKT_LEN-word packets
// FIFO_RD_STATS_EN adds the word_cnt/stall_cnt statistics counters.
module async_fifo_rd_streamer #(
    parameter int DSIZE   = 16,
    parameter int PKT_LEN = 8
`ifdef FIFO_RD_STATS_EN
    ,
    parameter int CNT_W   = 16
`endif
) (
    input  logic                      rclk,
    input  logic                      rrst,
    input  logic                      en,
    output logic                      rinc,
    input  logic [DSIZE-1:0]          rdata,
    input  logic                      rempty,
    async_fifo_rd_streamer_if.master  m,
    output logic                      busy
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [CNT_W-1:0]          word_cnt,
    output logic [CNT_W-1:0]          stall_cnt
`endif
);
    localparam int             BW       = $clog2(PKT_LEN);
    localparam logic [BW-1:0]  BEAT_MAX = BW'(PKT_LEN - 1);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t            state, state_nxt;
    logic [1:0]        occ, occ_nxt;
    logic [BW-1:0]     beat, beat_nxt;
    logic [DSIZE-1:0]  data0, data1;
    logic              last0, last1;
    logic              valid_q;
    logic              pop, hs, pop_last;

    assign pop      = !rempty && (state != IDLE) && (occ != 2'd2);
    assign hs       = valid_q && m.m_ready;
    assign pop_last = pop && (beat == BEAT_MAX);

    assign rinc     = pop;
    assign m.m_valid = valid_q;
    assign m.m_data  = data0;
    assign m.m_last  = last0;

    always_comb begin
        beat_nxt  = beat;
        occ_nxt   = occ;
        state_nxt = state;
        if (pop) begin
            beat_nxt = pop_last ? '0 : beat + BW'(1);
        end
        case ({pop, hs})
            2'b10:   occ_nxt = occ + 2'd1;
            2'b01:   occ_nxt = occ - 2'd1;
            default: occ_nxt = occ;
        endcase
        // Disable decisions use the post-pop beat so a pop in the same cycle cannot split a packet.
        case (state)
            IDLE:    if (en) state_nxt = RUN;
            RUN:     if (!en) state_nxt = (beat_nxt == '0) ? IDLE : FINISH;
            FINISH: begin
                if (en)            state_nxt = RUN;
                else if (pop_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state   <= IDLE;
            occ     <= 2'd0;
            beat    <= '0;
            data0   <= '0;
            data1   <= '0;
            last0   <= 1'b0;
            last1   <= 1'b0;
            valid_q <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            occ     <= occ_nxt;
            beat    <= beat_nxt;
            valid_q <= (occ_nxt != 2'd0);
            busy    <= (state_nxt != IDLE) || (occ_nxt != 2'd0);
            if (hs) begin
                data0 <= data1;
                last0 <= last1;
            end
            // A new word lands in the lowest slot left free after this cycle's shift.
            if (pop) begin
                if (occ == 2'd0 || hs) begin
                    data0 <= rdata;
                    last0 <= (beat == BEAT_MAX);
                end else begin
                    data1 <= rdata;
                    last1 <= (beat == BEAT_MAX);
                end
            end
        end
    end

`ifdef FIFO_RD_STATS_EN
    always_ff @(posedge rclk) begin
        if (rrst) begin
            word_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (hs && (word_cnt != '1)) begin
                word_cnt <= word_cnt + CNT_W'(1);
            end
            if ((state != IDLE) && rempty && (occ != 2'd2) && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end
`endif
endmodule

// File: tb/tb_async_fifo_rd_streamer.sv
// tb/tb_async_fifo_rd_streamer.sv - directed self-checking bench for async_fifo_rd_streamer
module tb_async_fifo_rd_streamer;
    logic        rclk = 1'b0;
    logic        rrst;
    logic        en;
    logic        rinc;
    logic [15:0] rdata;
    logic        rempty;
    logic        busy;
`ifdef FIFO_RD_STATS_EN
    logic [15:0] word_cnt;
    logic [15:0] stall_cnt;
`endif

    async_fifo_rd_streamer_if #(.DSIZE(16)) sif ();

    async_fifo_rd_streamer #(.DSIZE(16), .PKT_LEN(8)) dut (
        .rclk      (rclk),
        .rrst      (rrst),
        .en        (en),
        .rinc      (rinc),
        .rdata     (rdata),
        .rempty    (rempty),
        .m         (sif),
        .busy      (busy)
`ifdef FIFO_RD_STATS_EN
        ,
        .word_cnt  (word_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 rclk = ~rclk;

    int n_checks = 0;
    int n_errors = 0;
    int q[$];
    bit starve;
    bit sb_on;
    int pops, occ_model, exp_idx, sb_base;
    logic        s_rinc, s_valid, s_last, s_busy;
    logic [15:0] s_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_fifo();
        rempty = starve || (q.size() == 0);
        rdata  = (q.size() != 0) ? 16'(q[0]) : 16'h0;
    endtask

    task automatic fill_fifo();
        q.delete();
        for (int i = 0; i < 16; i++) q.push_back(i);
        drive_fifo();
    endtask

    // One clock: sample mid-cycle, then model the FIFO pop and handshake at the edge.
    task automatic step();
        bit p, h;
        #1;
        s_rinc  = rinc;
        s_valid = sif.m_valid;
        s_data  = sif.m_data;
        s_last  = sif.m_last;
        s_busy  = busy;
        p = (rinc === 1'b1) && !rempty;
        h = (sif.m_valid === 1'b1) && sif.m_ready;
        if (sb_on && s_valid === 1'b1) begin
            check("sb_data", 32'(s_data), 32'(exp_idx));
            check("sb_last", 32'(s_last), 32'(((exp_idx - sb_base) % 8) == 7));
        end
        if (occ_model == 2) check("rinc_when_full", 32'(s_rinc), 32'd0);
        @(posedge rclk);
        if (p) begin
            void'(q.pop_front());
            pops++;
        end
        if (rrst) begin
            occ_model = 0;
        end else begin
            if (p) occ_model++;
            if (h) begin
                occ_model--;
                exp_idx++;
            end
        end
        #1;
        drive_fifo();
    endtask

    task automatic new_test();
        sb_on = 1'b0;
        rrst  = 1'b1;
        step();
        rrst      = 1'b0;
        starve    = 1'b0;
        pops      = 0;
        exp_idx   = 0;
        sb_base   = 0;
        occ_model = 0;
        fill_fifo();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int guard;
        bit seen7, busy_checked;
        rrst = 1'b1; en = 1'b1; starve = 1'b0; sb_on = 1'b0; sif.m_ready = 1'b0;
        pops = 0; occ_model = 0; exp_idx = 0; sb_base = 0;
        fill_fifo();

        // Reset held with a non-empty FIFO and en=1
        @(posedge rclk); #1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_rinc", 32'(s_rinc), 32'd0);
            check("rst_valid", 32'(s_valid), 32'd0);
            check("rst_busy", 32'(s_busy), 32'd0);
            check("rst_data", 32'(s_data), 32'd0);
`ifdef FIFO_RD_STATS_EN
            check("rst_word_cnt", 32'(word_cnt), 32'd0);
            check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
        end
        check("rst_no_pop", 32'(q.size()), 32'd16);

        // Full-rate stream of 0..15
        rrst = 1'b0; sif.m_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            check("st_rinc", 32'(s_rinc), 32'((c >= 1) && (c <= 16)));
            check("st_valid", 32'(s_valid), 32'((c >= 2) && (c <= 17)));
            if (c >= 2 && c <= 17) begin
                check("st_data", 32'(s_data), 32'(c - 2));
                check("st_last", 32'(s_last), 32'((c - 2 == 7) || (c - 2 == 15)));
            end
        end
`ifdef FIFO_RD_STATS_EN
        check("st_word_cnt", 32'(word_cnt), 32'd16);
`endif

        // Alternating backpressure
        new_test();
        sb_on = 1'b1;
        guard = 0;
        while (exp_idx < 16 && guard < 100) begin
            sif.m_ready = (guard % 2 == 0);
            step();
            guard++;
        end
        check("bp_words", 32'(exp_idx), 32'd16);

        // Disable after 3 pops: packet completes then pops stop
        sif.m_ready = 1'b1;
        new_test();
        sb_on = 1'b1;
        guard = 0;
        while (pops < 3 && guard < 20) begin
            step();
            guard++;
        end
        check("bd_three_pops", 32'(pops), 32'd3);
        en = 1'b0;
        seen7 = 1'b0; busy_checked = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (seen7) begin
                check("bd_busy_after7", 32'(s_busy), 32'd0);
                busy_checked = 1'b1;
                seen7 = 1'b0;
            end
            if (s_valid === 1'b1 && s_data == 16'd7) begin
                check("bd_busy_on7", 32'(s_busy), 32'd1);
                seen7 = 1'b1;
            end
        end
        check("bd_busy_checked", 32'(busy_checked), 32'd1);
        check("bd_pops", 32'(pops), 32'd8);
        check("bd_words", 32'(exp_idx), 32'd8);
        check("bd_fifo_left", 32'(q.size()), 32'd8);
        check("bd_rinc_idle", 32'(s_rinc), 32'd0);

        // Starvation for 5 cycles after word 2
        en = 1'b1;
        new_test();
        sb_on = 1'b1;
        guard = 0;
        while (pops < 3 && guard < 20) begin
            step();
            guard++;
        end
`ifdef FIFO_RD_STATS_EN
        check("sv_stall_before", 32'(stall_cnt), 32'd0);
`endif
        starve = 1'b1;
        drive_fifo();
        for (int i = 0; i < 5; i++) begin
            step();
            check("sv_valid", 32'(s_valid), 32'(i == 0));
            check("sv_rinc", 32'(s_rinc), 32'd0);
        end
        starve = 1'b0;
        drive_fifo();
`ifdef FIFO_RD_STATS_EN
        check("sv_stall_after", 32'(stall_cnt), 32'd5);
`endif
        guard = 0;
        while (exp_idx < 16 && guard < 40) begin
            step();
            guard++;
        end
        check("sv_words", 32'(exp_idx), 32'd16);

        // Reset with occ=2 and beat=5
        new_test();
        sb_on = 1'b1;
        guard = 0;
        while (pops < 4 && guard < 20) begin
            step();
            guard++;
        end
        sif.m_ready = 1'b0;
        step();
        check("rm_pops", 32'(pops), 32'd5);
        rrst = 1'b1;
        step();
        check("rm_full_rinc", 32'(s_rinc), 32'd0);
        check("rm_full_valid", 32'(s_valid), 32'd1);
        rrst = 1'b0;
        exp_idx = 5; sb_base = 5;
        sif.m_ready = 1'b1;
        step();
        check("rm_valid_cleared", 32'(s_valid), 32'd0);
        check("rm_fifo_kept", 32'(q.size()), 32'd11);
        guard = 0;
        while (exp_idx < 16 && guard < 40) begin
            step();
            guard++;
        end
        check("rm_words", 32'(exp_idx), 32'd16);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/async_fifo_rd_streamer.md
# async_fifo_rd_streamer

Read-side consumer of `async_fifo`, on the `rclk` domain. Pops words from the FIFO's first-word-fall-through read port and buffers them in a registered 2-entry skid buffer. It then presents them as a valid/ready stream, tagging every `PKT_LEN`-th word with `m_last`. Enabling and disabling the streamer only takes effect on packet boundaries.

## Interface
- `DSIZE`, 16, data width; matches FIFO `DSIZE`.
- `PKT_LEN`, 8, words per packet; must be ≥ 2.
- `CNT_W`, 16, width of the statistics counters.

Ports:
- `rclk` in 1: the block's only clock.
- `rrst` in 1: synchronous, active-high reset.
- `en` in 1: streaming enable.
- `rinc` out 1: FIFO pop strobe. Drives the FIFO `rinc`; the bench gates it with `!rempty`.
- `rdata` in DSIZE: FIFO head word, valid whenever `rempty`=0.
- `rempty` in 1: FIFO empty flag.
- `m_valid` out 1: output word valid.
- `m_ready` in 1: downstream accept.
- `m_data` out DSIZE: output word.
- `m_last` out 1: final word of a packet.
- `busy` out 1: state ≠ IDLE or buffer not empty.
- `word_cnt` out CNT_W: only with `FIFO_RD_STATS_EN`.
- `stall_cnt` out CNT_W: only with `FIFO_RD_STATS_EN`.

## Operation
- Skid buffer: 2 entries of {data, last}, plus occupancy `occ` ∈ {0,1,2}. Entry 0 drives `m_data`/`m_last`; `m_valid` = (`occ` ≠ 0).
- Pop rule: `rinc` = `!rempty` & (state ∈ {RUN, FINISH}) & (`occ` < 2).
- Pop independence: `rinc` never depends combinationally on `m_ready`.
- On a pop, `rdata` is captured with `last` = (`beat` == `PKT_LEN`-1).
- `beat` counts pops modulo `PKT_LEN`; its width is clog2(`PKT_LEN`). It wraps to 0 after `PKT_LEN`-1.
- Simultaneous pop and handshake: `occ` is unchanged, and the words shift in order.
- Ordering: no word is dropped, duplicated or reordered.
- State machine:
  - IDLE → RUN when `en`=1.
  - RUN → FINISH when `en`=0 and `beat` ≠ 0.
  - RUN → IDLE when `en`=0 and `beat` == 0.
  - FINISH → IDLE after the pop that carries `last`.
  - FINISH → RUN if `en` returns to 1.
- IDLE behaviour: no pops; buffered words still drain to `m_*`.
- Statistics (with `FIFO_RD_STATS_EN`):
  - `word_cnt` increments on each `m_valid`&`m_ready`.
  - `stall_cnt` increments each cycle the block is in RUN/FINISH with `rempty`=1 and `occ` < 2.
  - Both counters saturate at all-ones.

## Timing
- Reset values:
  - `m_valid`=0, `m_data`=0, `m_last`=0, `busy`=0, `rinc`=0.
  - `occ`=0, `beat`=0, state=IDLE.
  - Counters=0.
- Reset mid-operation: buffered words are discarded and `beat` returns to 0. Reset does not touch the FIFO.
- Latency: a word popped at edge N is on `m_data` with `m_valid`=1 in cycle N+1.
- Throughput: with `m_ready`=1 and the FIFO non-empty, one word per `rclk`.
- Output hold: while `m_valid`=1 and `m_ready`=0, `m_data`/`m_last` stay stable.
- `m_valid` is deasserted only after a handshake.
- Output registers: `m_*` and `busy` are driven from registers. `rinc` is combinational from registered state and `rempty`.
- `occ`=2 with `m_ready`=1: no pop that cycle; `occ`=1 next cycle.
- `rempty` rising mid-packet: pops pause, `beat` is held, and streaming resumes in order.

## Configuration
- `FIFO_RD_STATS_EN` defined: the `word_cnt`/`stall_cnt` ports and counters exist.
- `FIFO_RD_STATS_EN` undefined: those ports and counters are absent. The datapath is cycle-identical in both builds.

## Test plan
- Reset: `rrst`=1 for 3 cycles with `rempty`=0 → `rinc`=0, `m_valid`=0, counters=0 throughout.
- Stream: FIFO holds 0..15, `en`=1, `m_ready`=1 → `m_data` shows 0..15 on consecutive cycles starting one cycle after the first pop; `m_last`=1 only on 7 and 15; `word_cnt`=16.
- Backpressure: 16 words with `m_ready` = 1,0,1,0,… → output 0..15 in order; `m_data` stable during stalls; `rinc`=0 whenever `occ`=2.
- Boundary disable: drop `en` after 3 pops → pops continue through word 7 (`m_last`=1), then `rinc`=0; `busy` falls once word 7 is accepted.
- Starvation: `rempty`=1 for 5 cycles after word 2 with `m_ready`=1 → `m_valid`=0 after word 2 drains; `stall_cnt` increases by 5; words 3.. resume, and `m_last` still falls on word 7.
- Reset mid-packet: assert `rrst` with `occ`=2 and `beat`=5 → next cycle `m_valid`=0; the first word popped after reset has `beat` 0, so `m_last` appears on its 8th word.
